// File: rtl/scan_loader_if.sv
// rtl/scan_loader_if.sv - host command/byte streams and buffer-bank serial port of scan_loader
//
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr : command handshake (target buffer, write or read)
//   wr_data/wr_valid/wr_ready              : byte stream into the selected chain
//   rd_data/rd_valid                       : captured bytes out, no back-pressure
//   done                                   : one-cycle command-complete strobe
//   sclk/sin/ssel/saddr/sout               : shared serial port of the eight pattern buffers
// Modports: master = host plus buffer bank side, slave = scan_loader.

interface scan_loader_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       sclk;
    logic       sin;
    logic       ssel;
    logic [2:0] saddr;
    logic       sout;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, wr_data, wr_valid, sout,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, sclk, sin, ssel, saddr
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, wr_data, wr_valid, sout,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, sclk, sin, ssel, saddr
    );
endinterface

// File: rtl/scan_loader.sv
// rtl/scan_loader.sv - serial scan-chain master that loads and reads back the pattern buffers
//
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   bus  : scan_loader_if.slave (command, write/read byte streams, done, serial port)
// Parameters:
//   buffer_size  : bytes per pattern buffer (chain length in bytes)
//   buffer_width : bits per byte, fixed at 8
//   clk_div      : core clocks per sclk period, even and >= 2
// Optional feature macro SCAN_READBACK_EN: when defined, cmd_write=0 performs a
// non-destructive read-back (sout recirculated to sin and captured onto rd_data).
// When undefined every command is a write and rd_valid/rd_data are tied low.

module scan_loader #(
    parameter int buffer_size  = 22,
    parameter int buffer_width = 8,
    parameter int clk_div      = 4
) (
    input logic          clk,
    input logic          rst,
    scan_loader_if.slave bus
);
    localparam int half   = clk_div / 2;
    localparam int byte_w = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam int half_w = (half > 1) ? $clog2(half) : 1;
    localparam int bit_w  = $clog2(buffer_width);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, FINISH} state_t;

    state_t                  state;
    logic [byte_w-1:0]       byte_cnt;
    logic [bit_w-1:0]        bit_cnt;
    logic [half_w-1:0]       phase_cnt;
    logic [buffer_width-1:0] shreg;
    logic                    write_mode;
    logic                    accept_write;
    logic                    sout_bit;

`ifdef SCAN_READBACK_EN
    logic [buffer_width-1:0] cap;
    assign accept_write = bus.cmd_write;
    assign sout_bit     = bus.sout;
`else
    logic unused_inputs;
    assign accept_write  = 1'b1;
    assign sout_bit      = 1'b0;
    assign unused_inputs = bus.cmd_write ^ bus.sout;
    assign bus.rd_valid  = 1'b0;
    assign bus.rd_data   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            bit_cnt       <= '0;
            phase_cnt     <= '0;
            shreg         <= '0;
            write_mode    <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.wr_ready  <= 1'b0;
            bus.done      <= 1'b0;
            bus.sclk      <= 1'b0;
            bus.sin       <= 1'b0;
            bus.ssel      <= 1'b0;
            bus.saddr     <= 3'd0;
`ifdef SCAN_READBACK_EN
            cap           <= '0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
`ifdef SCAN_READBACK_EN
            bus.rd_valid <= 1'b0;
`endif
            case (state)
                // FINISH also shows cmd_ready, so a command can be taken there directly.
                IDLE, FINISH: begin
                    if (bus.cmd_valid) begin
                        write_mode    <= accept_write;
                        bus.saddr     <= bus.cmd_addr;
                        bus.ssel      <= 1'b1;
                        bus.cmd_ready <= 1'b0;
                        bus.wr_ready  <= accept_write;
                        byte_cnt      <= '0;
                        state         <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end

                LOAD: begin
                    if (!write_mode || bus.wr_valid) begin
                        shreg        <= write_mode ? bus.wr_data : '0;
                        bus.sin      <= write_mode ? bus.wr_data[buffer_width-1] : sout_bit;
                        bus.wr_ready <= 1'b0;
                        bit_cnt      <= '0;
                        phase_cnt    <= '0;
                        state        <= SHIFT_LO;
                    end
                end

                SHIFT_LO: begin
                    if (phase_cnt == half_w'(half - 1)) begin
                        phase_cnt <= '0;
                        bus.sclk  <= 1'b1;
                        state     <= SHIFT_HI;
`ifdef SCAN_READBACK_EN
                        // Sampled on the same edge that raises sclk, before the chain shifts.
                        cap <= {cap[buffer_width-2:0], bus.sout};
`endif
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                SHIFT_HI: begin
                    if (phase_cnt == half_w'(half - 1)) begin
                        phase_cnt <= '0;
                        bus.sclk  <= 1'b0;
                        if (bit_cnt == bit_w'(buffer_width - 1)) begin
`ifdef SCAN_READBACK_EN
                            if (!write_mode) begin
                                bus.rd_data  <= cap;
                                bus.rd_valid <= 1'b1;
                            end
`endif
                            if (byte_cnt == byte_w'(buffer_size - 1)) begin
                                bus.ssel      <= 1'b0;
                                bus.sin       <= 1'b0;
                                bus.done      <= 1'b1;
                                bus.cmd_ready <= 1'b1;
                                state         <= FINISH;
                            end else begin
                                byte_cnt     <= byte_cnt + 1'b1;
                                bus.wr_ready <= write_mode;
                                state        <= LOAD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {shreg[buffer_width-2:0], 1'b0};
                            // Read-back feeds sout straight back so the chain is left intact.
                            bus.sin <= write_mode ? shreg[buffer_width-2] : sout_bit;
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/scan_loader.md
# scan_loader

Clocked serial scan-chain master that fills and reads back the eight pattern buffers over their shared serial port (sclk, sin, ssel, saddr, sout). A host supplies a command (target buffer, write or read) and a byte stream; the block generates a divided serial clock, shifts `buffer_size*buffer_width` bits through the selected chain and returns the displaced or recirculated contents byte by byte. It sits between the host/config bus and the buffer bank, on the core clock.

## Interface
Parameters:
- `buffer_size`, 22, bytes per pattern buffer (chain length in bytes)
- `buffer_width`, 8, bits per byte; fixed at 8 for this block
- `clk_div`, 4, core clocks per sclk period; even, >= 2

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  block idle, command accepted on `cmd_valid && cmd_ready`
- `cmd_write`  in  1  1 = load buffer from `wr_data`; 0 = non-destructive read-back
- `cmd_addr`  in  3  target buffer 0..7
- `wr_data`  in  8  next byte to load
- `wr_valid`  in  1  `wr_data` valid
- `wr_ready`  out  1  block requests a byte; consumed on `wr_valid && wr_ready`
- `rd_data`  out  8  byte captured from `sout`
- `rd_valid`  out  1  one-cycle strobe, `rd_data` valid; no back-pressure
- `done`  out  1  one-cycle strobe, command complete
- `sclk`  out  1  serial clock to buffers
- `sin`  out  1  serial data to buffers
- `ssel`  out  1  serial select
- `saddr`  out  3  buffer address, registered from `cmd_addr`
- `sout`  in  1  serial data from selected buffer

## Operation
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, FINISH.
- IDLE: `cmd_ready`=1. On accept latch `cmd_write`, `cmd_addr`; go LOAD; `ssel`=1, `saddr`=addr from next cycle until FINISH.
- LOAD (one per byte, bytes 0..buffer_size-1 in order): write mode asserts `wr_ready` and waits for `wr_valid` (sclk held low while waiting); read mode never waits. Loads an 8-bit shift register, go SHIFT_LO.
- SHIFT_LO (clk_div/2 cycles): `sclk`=0, `sin` = current bit, MSB first. Write mode: bit of loaded byte. Read mode: `sin` = `sout` (recirculate, chain contents preserved).
- SHIFT_HI (clk_div/2 cycles): `sclk`=1; `sout` sampled on the clk edge that drives `sclk` high, shifted into capture register MSB first. After 8th bit: next byte -> LOAD, last byte -> FINISH.
- Captured byte presented on `rd_data` with `rd_valid`=1 in the following LOAD or FINISH cycle; read mode only.
- Bit order makes the chain FIFO-like: a read after a write returns byte 0 first, identical values.
- FINISH: one cycle, `ssel`=0, `sclk`=0, `done`=1, `cmd_ready`=1; returns to IDLE.
- `cmd_valid` while busy ignored. `wr_valid` outside LOAD ignored.

## Timing
- Reset values: `cmd_ready`=1; `wr_ready`, `rd_valid`, `done`, `sclk`, `sin`, `ssel`=0; `saddr`=0; `rd_data`=0.
- All outputs registered; `sclk` glitch-free, low whenever `ssel`=0.
- Accept at cycle T: `ssel` high from T+1. Per byte without stall 1+8*clk_div cycles. `done` at T+1+buffer_size*(1+8*clk_div); defaults T+727.
- Write stall: each cycle `wr_valid`=0 in LOAD adds one cycle; `sclk` stays low.
- `rst` mid-command: outputs return to reset values immediately; no `done`; partial chain contents undefined; next command must reload.

## Configuration
- `SCAN_READBACK_EN` defined: read mode, `sout` capture and `rd_valid`/`rd_data` as above.
- Not defined: `cmd_write` ignored (every command is write), `rd_valid`/`rd_data` tied 0, `sout` unused; no capture register.

## Test plan
- Reset -> all outputs at reset values, `cmd_ready`=1, `sclk` idle low for 20 cycles.
- Write addr 3, bytes 0x00..0x15, `wr_valid` held high -> `saddr`=3, exactly 176 sclk rising edges, `sin` MSB first, `done` at T+727.
- Write then read addr 5 (bytes 0xA5,0x5A,...) -> 22 `rd_valid` strobes equal to written bytes in order; second read returns same bytes.
- Write with `wr_valid` dropped 10 cycles before byte 7 -> `sclk` low throughout stall, `done` at T+737, chain data correct.
- `rst` asserted at bit 50 -> `ssel`,`sclk`=0 same cycle, no `done`; fresh command after release completes normally.
- `SCAN_READBACK_EN` undefined, command with `cmd_write`=0 -> treated as write, `rd_valid` never asserts.
